mat_a_fetch: RTL and testbench
==============================

Name: mat_a_fetch

Overview:
Read sequencer feeding matrix-A operands from the A data memory to the downstream multiply-accumulate stage. On start it walks an N x N row-major matrix. Each row is replayed N times, once per column of B, so the MAC sees the full dot-product operand stream for C = A x B. Memory read latency is absorbed by a credit-controlled output FIFO with a valid/ready handshake.

Parameters:
N, 4, matrix dimension (2..16)
ADDR_W, 16, memory address width
DATA_W, 16, element width
RD_LAT, 2, cycles from mem_rd_en/mem_addr sampled to mem_rdata valid (>=1)
FIFO_DEPTH, 4, output FIFO entries (>=2, power of 2)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a pass; sampled only in IDLE
base_addr  in  ADDR_W  address of A[0][0]; latched on accepted start
mem_addr  out  ADDR_W  read address to A memory
mem_rd_en  out  1  read strobe; memory write enable is tied low by the instantiating level
mem_rdata  in  DATA_W  read data, valid RD_LAT cycles after strobe
out_data  out  DATA_W  operand A[row][k]
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts when valid&ready
out_last  out  1  k == N-1, i.e. end of one dot product
out_row_last  out  1  k == N-1 and rep == N-1, i.e. end of a row's last replay
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after final element handshake

Behaviour:
- Reset values: mem_addr=0, mem_rd_en=0, out_valid=0, out_data=0, out_last=0, out_row_last=0, busy=0, done=0. Reset also clears the FIFO, the in-flight pipeline and all counters.
- Reset is asynchronous and may occur mid-pass. Returning read data after reset is discarded. No spurious out_valid occurs.
- FSM states: IDLE, ISSUE, DRAIN, FINISH.
  - IDLE -> ISSUE when start=1. Latch base_addr, clear counters, busy=1.
  - ISSUE issues one read per cycle when credit is available: (fifo_count + inflight) < FIFO_DEPTH.
  - ISSUE -> DRAIN after the read for (row=N-1, rep=N-1, k=N-1) is issued.
  - DRAIN -> FINISH when inflight=0, FIFO empty, and the last element has handshaked.
  - FINISH: done=1 for one cycle, busy=0, then -> IDLE.
- Loop order: row outer, rep middle, k inner. mem_addr = base + row*N + k, computed modulo 2^ADDR_W (wrap permitted).
- Flags: last/row_last are computed at issue time and travel through an RD_LAT-deep shift pipeline alongside a valid bit. They are written to the FIFO together with mem_rdata.
- Latency, no backpressure: first mem_rd_en in cycle 1 after start is sampled. The FIFO is written in cycle 1+RD_LAT. out_valid is first asserted in cycle 2+RD_LAT. Sustained throughput is 1 element/cycle when FIFO_DEPTH >= RD_LAT+1.
- Backpressure: out_data/out_last/out_row_last hold stable while out_valid & !out_ready. Credits guarantee the FIFO never overflows.
- FIFO edge cases:
  - Simultaneous FIFO push and pop at full or empty is legal; the count is unchanged.
  - FIFO empty -> out_valid=0.
- start while busy is ignored. start asserted in the same cycle as done is ignored.
- Total elements per pass: N^3.

Optional Feature:
TRANSPOSE_EN
- Defined: mem_addr = base + k*N + row, so A is read column-major (A stored transposed). Flags and loop order are unchanged.
- Undefined: row-major addressing only. No transpose logic is present.

Decomposition:
- Package mat_pkg:
  - typedef for the FIFO entry struct {data, last, row_last}
  - FSM state enum
  - localparam for counter width, clog2(N)
- One sub-module is natural: sync_fifo (parameterised DEPTH and WIDTH, count output), reusable by the B-side fetcher.

Test Plan:
- N=2, base=0x0010, out_ready=1 -> addresses 0x10,0x11,0x10,0x11,0x12,0x13,0x12,0x13. out_data follows memory contents. out_last on elements 2,4,6,8; out_row_last on 4,8; done pulse once; 8 handshakes total.
- Same pass with out_ready toggling 1,0,0,1... -> data and flags stable while stalled. No drops or duplicates. Inflight+count never exceeds FIFO_DEPTH; mem_rd_en deasserts when credits are exhausted.
- base=0xFFFE, N=2 -> addresses 0xFFFE,0xFFFF,0xFFFE,0xFFFF,0x0000,0x0001,0x0000,0x0001.
- rst_n low in cycle 5 of a pass -> all outputs 0 immediately. After release, no out_valid until a new start. A new pass completes correctly.
- start pulsed while busy -> ignored; exactly one done, N^3 elements.
- TRANSPOSE_EN, N=2, base=0 -> addresses 0,2,0,2,1,3,1,3.

Source files
------------

// File: rtl/mat_pkg.sv
// Shared types for the matrix operand fetchers: FIFO entry layout, fetch FSM
// states and counter sizing.
package mat_pkg;

   localparam int MAT_N      = 4;
   localparam int MAT_DATA_W = 16;

   typedef struct packed {
      logic [MAT_DATA_W-1:0] data;
      logic                  last;
      logic                  row_last;
   } a_entry_t;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ISSUE  = 2'd1,
      S_DRAIN  = 2'd2,
      S_FINISH = 2'd3
   } fetch_state_t;

   // Counter width for indices 0..n-1; never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; power-of-two DEPTH, head visible on
// o_rdata whenever o_empty is low.
module sync_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 18
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_rdata,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_full;
   logic             w_push;
   logic             w_pop;

   assign o_empty = (r_count == '0);
   assign w_full  = (r_count == CW'(DEPTH));
   assign w_pop   = i_pop & ~o_empty;
   // A push into a full FIFO is only taken when the head leaves in the same cycle.
   assign w_push  = i_push & (~w_full | w_pop);
   assign o_rdata = r_mem[r_rd_ptr];
   assign o_count = r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_wdata;
   end

endmodule

// File: rtl/mat_a_fetch.sv
// Matrix-A operand fetcher: walks row/rep/k, issues credit-limited reads and
// streams operands through a FIFO. Define TRANSPOSE_EN for column-major A.
//
// state    | meaning
// ---------+----------------------------------------------
// S_IDLE   | waiting for start
// S_ISSUE  | issuing reads while credit is available
// S_DRAIN  | all reads issued, waiting for pipeline + FIFO
// S_FINISH | done pulse, back to idle
module mat_a_fetch
   import mat_pkg::*;
#(
   parameter int N          = MAT_N,
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = MAT_DATA_W,
   parameter int RD_LAT     = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd_en,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              out_row_last,
   output logic              busy,
   output logic              done
);

   localparam int CW = cnt_w(N);
   localparam int FW = $clog2(FIFO_DEPTH) + 1;
   localparam int UW = FW + 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

   fetch_state_t      r_state;
   fetch_state_t      w_next;
   logic [ADDR_W-1:0] r_base;
   logic [CW-1:0]     r_row;
   logic [CW-1:0]     r_rep;
   logic [CW-1:0]     r_k;
   logic [FW-1:0]     r_inflight;
   logic              r_pv  [RD_LAT];
   logic              r_pl  [RD_LAT];
   logic              r_prl [RD_LAT];

   logic              w_k_end;
   logic              w_rep_end;
   logic              w_row_end;
   logic              w_credit;
   logic              w_issue;
   logic              w_push;
   logic              w_pop;
   logic              w_empty;
   logic [FW-1:0]     w_count;
   logic [UW-1:0]     w_used;
   logic [ADDR_W-1:0] w_off;
   a_entry_t          w_wr;
   a_entry_t          w_rd;

   assign w_k_end   = (r_k == LAST_IDX);
   assign w_rep_end = (r_rep == LAST_IDX);
   assign w_row_end = (r_row == LAST_IDX);

   // Credits count both queued and still-in-flight reads so the FIFO cannot overflow.
   assign w_used   = UW'(w_count) + UW'(r_inflight);
   assign w_credit = (w_used < UW'(FIFO_DEPTH));
   assign w_issue  = (r_state == S_ISSUE) & w_credit;

`ifdef TRANSPOSE_EN
   assign w_off = ADDR_W'(r_k) * ADDR_W'(N) + ADDR_W'(r_row);
`else
   assign w_off = ADDR_W'(r_row) * ADDR_W'(N) + ADDR_W'(r_k);
`endif

   assign mem_addr  = r_base + w_off;
   assign mem_rd_en = w_issue;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (start) w_next = S_ISSUE;
         S_ISSUE:  if (w_issue && w_k_end && w_rep_end && w_row_end) w_next = S_DRAIN;
         S_DRAIN:  if ((r_inflight == '0) && w_empty) w_next = S_FINISH;
         S_FINISH: w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_base <= '0;
         r_row  <= '0;
         r_rep  <= '0;
         r_k    <= '0;
      end else if ((r_state == S_IDLE) && start) begin
         r_base <= base_addr;
         r_row  <= '0;
         r_rep  <= '0;
         r_k    <= '0;
      end else if (w_issue) begin
         if (!w_k_end) begin
            r_k <= r_k + 1'b1;
         end else begin
            r_k <= '0;
            if (w_rep_end) begin
               r_rep <= '0;
               r_row <= r_row + 1'b1;
            end else begin
               r_rep <= r_rep + 1'b1;
            end
         end
      end
   end

   // Flag pipeline matches memory latency; its tail marks when mem_rdata is valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < RD_LAT; i++) begin
            r_pv[i]  <= 1'b0;
            r_pl[i]  <= 1'b0;
            r_prl[i] <= 1'b0;
         end
         r_inflight <= '0;
      end else begin
         r_pv[0]  <= w_issue;
         r_pl[0]  <= w_k_end;
         r_prl[0] <= w_k_end & w_rep_end;
         for (int i = 1; i < RD_LAT; i++) begin
            r_pv[i]  <= r_pv[i-1];
            r_pl[i]  <= r_pl[i-1];
            r_prl[i] <= r_prl[i-1];
         end
         r_inflight <= r_inflight + FW'(w_issue) - FW'(w_push);
      end
   end

   assign w_push      = r_pv[RD_LAT-1];
   assign w_wr.data     = MAT_DATA_W'(mem_rdata);
   assign w_wr.last     = r_pl[RD_LAT-1];
   assign w_wr.row_last = r_prl[RD_LAT-1];
   assign w_pop       = out_valid & out_ready;

   sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(a_entry_t))
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_wdata (w_wr),
      .i_pop   (w_pop),
      .o_rdata (w_rd),
      .o_count (w_count),
      .o_empty (w_empty)
   );

   assign out_valid    = ~w_empty;
   assign out_data     = out_valid ? DATA_W'(w_rd.data) : '0;
   assign out_last     = out_valid & w_rd.last;
   assign out_row_last = out_valid & w_rd.row_last;
   assign busy         = (r_state == S_ISSUE) || (r_state == S_DRAIN);
   assign done         = (r_state == S_FINISH);

endmodule

// File: tb/tb_mat_a_fetch.sv
// Directed bench for mat_a_fetch at N=2, RD_LAT=2, FIFO_DEPTH=4; honours
// TRANSPOSE_EN when it is defined for the build.
module tb_mat_a_fetch;

   localparam int N  = 2;
   localparam int AW = 16;
   localparam int DW = 16;
   localparam int RL = 2;
   localparam int FD = 4;
   localparam int NE = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [AW-1:0] mem_addr;
   logic          mem_rd_en;
   logic [DW-1:0] mem_rdata;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic          out_last;
   logic          out_row_last;
   logic          busy;
   logic          done;

   mat_a_fetch #(
      .N(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL), .FIFO_DEPTH(FD)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
      .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .out_row_last(out_row_last), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] mem_val(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'h5A3C;
   endfunction

   logic [DW-1:0] rd_pipe [RL];
   always @(posedge clk) begin
      rd_pipe[0] <= mem_val(mem_addr);
      for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign mem_rdata = rd_pipe[RL-1];

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [15:0] got_addr [16];
   logic [15:0] got_data [16];
   logic [15:0] got_last;
   logic [15:0] got_rl;
   int n_addr, n_out, n_done, stall_viol, max_out, first_rd, first_val;
   logic        prev_stall;
   logic [17:0] prev_bus;

   typedef struct {
      logic [15:0] base;
      int          mode;
      logic [15:0] addr [8];
   } vec_t;
   vec_t vecs [4];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic clear_mon();
      n_addr = 0; n_out = 0; n_done = 0; stall_viol = 0; max_out = 0;
      first_rd = -1; first_val = -1; prev_stall = 1'b0; prev_bus = '0;
      got_last = '0; got_rl = '0;
      for (int i = 0; i < 16; i++) begin
         got_addr[i] = '0;
         got_data[i] = '0;
      end
   endtask

   task automatic sample();
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (mem_rd_en) begin
            if (n_addr < 16) got_addr[n_addr] = mem_addr;
            if (n_addr == 0) first_rd = cyc;
            n_addr++;
         end
         if (n_addr - n_out > max_out) max_out = n_addr - n_out;
         if (prev_stall && !(out_valid && ({out_data, out_last, out_row_last} === prev_bus)))
            stall_viol++;
         if (out_valid && out_ready) begin
            if (n_out < 16) begin
               got_data[n_out] = out_data;
               got_last[n_out] = out_last;
               got_rl[n_out]   = out_row_last;
            end
            if (n_out == 0) first_val = cyc;
            n_out++;
         end
         prev_stall = out_valid && !out_ready;
         prev_bus   = {out_data, out_last, out_row_last};
         if (done) n_done++;
      end
   endtask

   // Sample at the falling edge, then land 1 time unit after the next rising edge.
   task automatic cycle();
      @(negedge clk);
      sample();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   function automatic logic ready_at(input int mode, input int s);
      case (mode)
         1:       return (s % 3) == 0;
         2:       return (s % 2) == 1;
         default: return 1'b1;
      endcase
   endfunction

   task automatic run_pass(input logic [15:0] base, input int mode, output int t0);
      clear_mon();
      base_addr = base;
      start     = 1'b1;
      out_ready = ready_at(mode, 0);
      t0 = cyc;
      cycle();
      start = 1'b0;
      for (int s = 1; s < 300; s++) begin
         if (n_done > 0) break;
         out_ready = ready_at(mode, s);
         cycle();
      end
      out_ready = 1'b1;
      repeat (6) cycle();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      logic [127:0] aa, ea, ad, ed;

`ifdef TRANSPOSE_EN
      vecs[0] = '{16'h0010, 0, '{16'h0010, 16'h0012, 16'h0010, 16'h0012, 16'h0011, 16'h0013, 16'h0011, 16'h0013}};
      vecs[1] = '{16'h0010, 1, '{16'h0010, 16'h0012, 16'h0010, 16'h0012, 16'h0011, 16'h0013, 16'h0011, 16'h0013}};
      vecs[2] = '{16'hFFFE, 0, '{16'hFFFE, 16'h0000, 16'hFFFE, 16'h0000, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0001}};
      vecs[3] = '{16'h0000, 2, '{16'h0000, 16'h0002, 16'h0000, 16'h0002, 16'h0001, 16'h0003, 16'h0001, 16'h0003}};
`else
      vecs[0] = '{16'h0010, 0, '{16'h0010, 16'h0011, 16'h0010, 16'h0011, 16'h0012, 16'h0013, 16'h0012, 16'h0013}};
      vecs[1] = '{16'h0010, 1, '{16'h0010, 16'h0011, 16'h0010, 16'h0011, 16'h0012, 16'h0013, 16'h0012, 16'h0013}};
      vecs[2] = '{16'hFFFE, 0, '{16'hFFFE, 16'hFFFF, 16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 16'h0000, 16'h0001}};
      vecs[3] = '{16'h0000, 2, '{16'h0000, 16'h0001, 16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0002, 16'h0003}};
`endif

      rst_n = 1'b0; start = 1'b0; out_ready = 1'b0; base_addr = '0;
      clear_mon();
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs",
            {mem_addr, mem_rd_en, out_valid, out_data, out_last, out_row_last, busy, done}, '0);
      rst_n = 1'b1;
      cycle();

      // Reset in the middle of a pass.
      clear_mon();
      base_addr = 16'h0040;
      start = 1'b1;
      out_ready = 1'b1;
      cycle();
      start = 1'b0;
      repeat (4) cycle();
      check("busy_mid_pass", busy, 1'b1);
      check("reads_before_reset", (n_addr > 0), 1'b1);
      rst_n = 1'b0;
      #1;
      check("async_reset_outputs",
            {mem_addr, mem_rd_en, out_valid, out_data, out_last, out_row_last, busy, done}, '0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      clear_mon();
      repeat (10) cycle();
      check("post_reset_quiet", {32'(n_addr), 32'(n_out), 32'(n_done)}, '0);

      for (int v = 0; v < 4; v++) begin
         run_pass(vecs[v].base, vecs[v].mode, t0);
         aa = '0; ea = '0; ad = '0; ed = '0;
         for (int i = 0; i < NE; i++) begin
            aa = {aa[111:0], got_addr[i]};
            ea = {ea[111:0], vecs[v].addr[i]};
            ad = {ad[111:0], got_data[i]};
            ed = {ed[111:0], mem_val(vecs[v].addr[i])};
         end
         check($sformatf("v%0d_addr_seq", v), aa, ea);
         check($sformatf("v%0d_data_seq", v), ad, ed);
         check($sformatf("v%0d_last", v), got_last[7:0], 8'hAA);
         check($sformatf("v%0d_row_last", v), got_rl[7:0], 8'h88);
         check($sformatf("v%0d_counts", v), {32'(n_addr), 32'(n_out), 32'(n_done)},
               {32'(NE), 32'(NE), 32'd1});
         check($sformatf("v%0d_stall_stable", v), 32'(stall_viol), 32'd0);
         check($sformatf("v%0d_credit_bound", v), (max_out <= FD), 1'b1);
         check($sformatf("v%0d_idle_after", v), {busy, done, out_valid}, 3'b000);
         if (vecs[v].mode == 0) begin
            check($sformatf("v%0d_first_rd_cycle", v), 32'(first_rd - t0), 32'd1);
            check($sformatf("v%0d_first_valid_cycle", v), 32'(first_val - t0), 32'(2 + RL));
         end
         if (vecs[v].mode == 1)
            check($sformatf("v%0d_credit_exhausted", v), 32'(max_out), 32'(FD));
      end

      // start held high through the whole pass, including the done cycle.
      clear_mon();
      base_addr = 16'h0020;
      start = 1'b1;
      out_ready = 1'b1;
      for (int s = 0; s < 300; s++) begin
         cycle();
         if (n_done > 0) break;
      end
      start = 1'b0;
      repeat (10) cycle();
      check("held_start_counts", {32'(n_addr), 32'(n_out), 32'(n_done)},
            {32'(NE), 32'(NE), 32'd1});
      check("held_start_first_addr", got_addr[0], 16'h0020);
      check("held_start_idle", {busy, out_valid}, 2'b00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
